// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the datapath command sequencer: ALU opcodes, cmd word
// layout and controller state encoding.
package dp_ctrl_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned OpW      = 4;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned ShamtW   = 5;

  localparam logic [OpW-1:0] OpAdd = 4'd0;
  localparam logic [OpW-1:0] OpSub = 4'd1;
  localparam logic [OpW-1:0] OpAnd = 4'd2;
  localparam logic [OpW-1:0] OpOr  = 4'd3;
  localparam logic [OpW-1:0] OpXor = 4'd4;
  localparam logic [OpW-1:0] OpSll = 4'd5;
  localparam logic [OpW-1:0] OpSra = 4'd6;
  localparam logic [OpW-1:0] OpSrl = 4'd7;
  localparam logic [OpW-1:0] OpLt  = 4'd8;
  localparam logic [OpW-1:0] OpMax = OpLt;

  localparam int unsigned CmdLiBit    = 31;
  localparam int unsigned CmdOpLsb    = 27;
  localparam int unsigned CmdRdLsb    = 22;
  localparam int unsigned CmdRsLsb    = 17;
  localparam int unsigned CmdRtLsb    = 12;
  localparam int unsigned CmdShamtLsb = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  // Only the adder/subtractor ops can be suppressed by an overflow.
  function automatic logic op_is_addsub(logic [OpW-1:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/dp_seq_ctrl_if.sv
// Command/response handshake between an instruction source and dp_seq_ctrl.
interface dp_seq_ctrl_if;
  import dp_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DataW-1:0] cmd;
  logic [DataW-1:0] cmd_imm;
  logic             rsp_valid;
  logic             rsp_ovf;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd, cmd_imm,
    input  cmd_ready, rsp_valid, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_imm,
    output cmd_ready, rsp_valid, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/dp_cmd_decode.sv
// Combinational field extractor for the 32-bit sequencer command word.
module dp_cmd_decode
  import dp_ctrl_pkg::*;
(
  input  logic [DataW-1:0]    cmd,
  output logic                li,
  output logic [OpW-1:0]      op,
  output logic [RegAddrW-1:0] rd,
  output logic [RegAddrW-1:0] rs,
  output logic [RegAddrW-1:0] rt,
  output logic [ShamtW-1:0]   shamt,
  output logic                illegal
);

  assign li      = cmd[CmdLiBit];
  assign op      = cmd[CmdOpLsb +: OpW];
  assign rd      = cmd[CmdRdLsb +: RegAddrW];
  assign rs      = cmd[CmdRsLsb +: RegAddrW];
  assign rt      = cmd[CmdRtLsb +: RegAddrW];
  assign shamt   = cmd[CmdShamtLsb +: ShamtW];
  // Load-immediate ignores the opcode field, so it can never be illegal.
  assign illegal = !li && (op > OpMax);

  logic unused_reserved;
  assign unused_reserved = ^cmd[CmdShamtLsb-1:0];

endmodule

// File: rtl/dp_seq_ctrl.sv
// Three-state command sequencer (IDLE -> EXEC -> WB) driving the register file,
// ALU and write-back mux, with a per-command response and overflow counter.
module dp_seq_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  dp_seq_ctrl_if.slave        bus,
  output logic [RegAddrW-1:0] rd_addr1,
  output logic [RegAddrW-1:0] rd_addr2,
  output logic [RegAddrW-1:0] wr_addr,
  output logic                wr_en,
  output logic                mux_sel,
  output logic [DataW-1:0]    imm_data,
  output logic [OpW-1:0]      alu_op,
  output logic [ShamtW-1:0]   alu_shft,
  input  logic                alu_overflow,
  output logic [CNT_W-1:0]    ovf_cnt
);

  state_e state_q, state_d;

  logic                dec_li;
  logic [OpW-1:0]      dec_op;
  logic [RegAddrW-1:0] dec_rd;
  logic [RegAddrW-1:0] dec_rs;
  logic [RegAddrW-1:0] dec_rt;
  logic [ShamtW-1:0]   dec_shamt;
  logic                dec_illegal;

  dp_cmd_decode u_decode (
    .cmd     (bus.cmd),
    .li      (dec_li),
    .op      (dec_op),
    .rd      (dec_rd),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .shamt   (dec_shamt),
    .illegal (dec_illegal)
  );

  logic                li_q;
  logic                illegal_q;
  logic                mux_sel_q;
  logic [OpW-1:0]      op_q;
  logic [RegAddrW-1:0] rd_q;
  logic [RegAddrW-1:0] rs_q;
  logic [RegAddrW-1:0] rt_q;
  logic [ShamtW-1:0]   shamt_q;
  logic [DataW-1:0]    imm_q;
  logic                ovf_hit_q, ovf_hit_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;

  logic cmd_ready;
  logic accept;
  logic wr_en_int;
  logic rsp_valid;
  logic rsp_ovf;
  logic rsp_err;

  assign accept = cmd_ready && bus.cmd_valid;

  always_comb begin
    state_d   = state_q;
    ovf_hit_d = ovf_hit_q;
    ovf_cnt_d = ovf_cnt_q;
    cmd_ready = 1'b0;
    wr_en_int = 1'b0;
    rsp_valid = 1'b0;
    rsp_ovf   = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = StExec;
      end
      StExec: begin
        // Written as an if so an unknown flag falls through as "no overflow".
        ovf_hit_d = 1'b0;
        if ((alu_overflow == 1'b1) && !li_q && op_is_addsub(op_q)) ovf_hit_d = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        wr_en_int = !ovf_hit_q && !illegal_q;
        rsp_valid = 1'b1;
        rsp_ovf   = ovf_hit_q;
        rsp_err   = illegal_q;
        if (ovf_hit_q && (ovf_cnt_q != {CNT_W{1'b1}})) ovf_cnt_d = ovf_cnt_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ovf_hit_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ovf_hit_q <= ovf_hit_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Command fields are captured once at acceptance and held through EXEC and WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      li_q      <= 1'b0;
      illegal_q <= 1'b0;
      mux_sel_q <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      shamt_q   <= '0;
      imm_q     <= '0;
    end else if (accept) begin
      li_q      <= dec_li;
      illegal_q <= dec_illegal;
      mux_sel_q <= !dec_li;
      op_q      <= dec_op;
      rd_q      <= dec_rd;
      rs_q      <= dec_rs;
      rt_q      <= dec_rt;
      shamt_q   <= dec_shamt;
      imm_q     <= bus.cmd_imm;
    end
  end

  assign rd_addr1      = rs_q;
  assign rd_addr2      = rt_q;
  assign wr_addr       = rd_q;
  assign alu_op        = op_q;
  assign alu_shft      = shamt_q;
  assign mux_sel       = mux_sel_q;
  assign imm_data      = imm_q;
  assign wr_en         = wr_en_int;
  assign ovf_cnt       = ovf_cnt_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_ovf   = rsp_ovf;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Bench for dp_seq_ctrl with a behavioural register file, ALU and write-back mux;
// results are checked against an arithmetic reference model of each command.
module tb_dp_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        rf_rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic        wr_en, mux_sel, alu_overflow;
  logic [31:0] imm_data;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shft;
  logic [7:0]  ovf_cnt;

  dp_seq_ctrl_if bus_if ();

  dp_seq_ctrl #(
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .mux_sel      (mux_sel),
    .imm_data     (imm_data),
    .alu_op       (alu_op),
    .alu_shft     (alu_shft),
    .alu_overflow (alu_overflow),
    .ovf_cnt      (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-ins: register i resets to i; the ALU flags adder overflow for
  // every op except SUB, so the controller's opcode gating is exercised.
  logic [31:0] rf [32];
  logic [31:0] alu_a, alu_b, alu_res;
  logic [32:0] alu_sum, alu_diff;

  always @(posedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
    end else if (wr_en) begin
      rf[wr_addr] <= mux_sel ? alu_res : imm_data;
    end
  end

  always_comb begin
    alu_a    = rf[rd_addr1];
    alu_b    = rf[rd_addr2];
    alu_sum  = {alu_a[31], alu_a} + {alu_b[31], alu_b};
    alu_diff = {alu_a[31], alu_a} - {alu_b[31], alu_b};
    alu_res  = '0;
    case (alu_op)
      4'd0: alu_res = alu_a + alu_b;
      4'd1: alu_res = alu_a - alu_b;
      4'd2: alu_res = alu_a & alu_b;
      4'd3: alu_res = alu_a | alu_b;
      4'd4: alu_res = alu_a ^ alu_b;
      4'd5: alu_res = alu_a << alu_shft;
      4'd6: alu_res = $signed(alu_a) >>> alu_shft;
      4'd7: alu_res = alu_a >> alu_shft;
      4'd8: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
    alu_overflow = (alu_op == 4'd1) ? (alu_diff[32] != alu_diff[31])
                                    : (alu_sum[32] != alu_sum[31]);
  end

  // Reference model state.
  logic [31:0] exp_rf [32];
  int          exp_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit li, input int unsigned op, input int unsigned rd,
                                     input int unsigned rs, input int unsigned rt,
                                     input int unsigned sh);
    logic [31:0] c;
    c        = '0;
    c[31]    = li;
    c[30:27] = 4'(op);
    c[26:22] = 5'(rd);
    c[21:17] = 5'(rs);
    c[16:12] = 5'(rt);
    c[11:7]  = 5'(sh);
    return c;
  endfunction

  // Signed results computed as plain integers, then reduced modulo 2^32.
  function automatic void ref_exec(input logic [31:0] c, input logic [31:0] imm,
                                   output bit wen, output logic [31:0] val,
                                   output bit ovf, output bit err);
    int unsigned op, rs, rt, sh;
    longint sa, sb, ua, r, p;
    op  = 32'(c[30:27]);
    rs  = 32'(c[21:17]);
    rt  = 32'(c[16:12]);
    sh  = 32'(c[11:7]);
    sa  = longint'($signed(exp_rf[rs]));
    sb  = longint'($signed(exp_rf[rt]));
    ua  = longint'(exp_rf[rs]);
    p   = longint'(1) << sh;
    ovf = 1'b0;
    err = 1'b0;
    r   = 0;
    if (c[31]) begin
      wen = 1'b1;
      val = imm;
      return;
    end
    case (op)
      0: begin r = sa + sb; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      1: begin r = sa - sb; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      2: r = longint'(exp_rf[rs] & exp_rf[rt]);
      3: r = longint'(exp_rf[rs] | exp_rf[rt]);
      4: r = longint'(exp_rf[rs] ^ exp_rf[rt]);
      5: r = ua * p;
      6: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      7: r = ua / p;
      8: r = (sa < sb) ? 1 : 0;
      default: err = 1'b1;
    endcase
    wen = !ovf && !err;
    val = r[31:0];
  endfunction

  // Issue one command at a negedge with the DUT idle and check it through WB.
  task automatic run_cmd(input logic [31:0] c, input logic [31:0] imm, input bit hold,
                         input logic [31:0] nc, input logic [31:0] nimm);
    bit          wen, ovf, err;
    logic [31:0] val;
    int unsigned rd;
    ref_exec(c, imm, wen, val, ovf, err);
    rd = 32'(c[26:22]);
    check("ready_idle", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd       = c;
    bus_if.cmd_imm   = imm;
    @(posedge clk);
    last_acc = cyc;
    #1;
    if (hold) begin
      bus_if.cmd     = nc;
      bus_if.cmd_imm = nimm;
    end else begin
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd       = $urandom;
      bus_if.cmd_imm   = $urandom;
    end
    @(negedge clk);
    check("exec_ready", 32'(bus_if.cmd_ready), 32'd0);
    check("exec_wr_en", 32'(wr_en), 32'd0);
    check("exec_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("exec_rd_addr1", 32'(rd_addr1), 32'(c[21:17]));
    check("exec_rd_addr2", 32'(rd_addr2), 32'(c[16:12]));
    check("exec_wr_addr", 32'(wr_addr), rd);
    check("exec_alu_op", 32'(alu_op), 32'(c[30:27]));
    check("exec_alu_shft", 32'(alu_shft), 32'(c[11:7]));
    check("exec_mux_sel", 32'(mux_sel), 32'(!c[31]));
    check("exec_imm", imm_data, imm);
    @(negedge clk);
    check("wb_ready", 32'(bus_if.cmd_ready), 32'd0);
    check("wb_wr_en", 32'(wr_en), 32'(wen));
    check("wb_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("wb_rsp_ovf", 32'(bus_if.rsp_ovf), 32'(ovf));
    check("wb_rsp_err", 32'(bus_if.rsp_err), 32'(err));
    check("wb_wr_addr", 32'(wr_addr), rd);
    if (ovf) exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
    if (wen) exp_rf[rd] = val;
    @(negedge clk);
    check("post_wr_en", 32'(wr_en), 32'd0);
    check("post_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("post_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("post_ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
    check("post_reg", rf[rd], exp_rf[rd]);
  endtask

  initial begin
    int unsigned acc1;
    logic [31:0] c, c2;
    rst              = 1'b1;
    rf_rst           = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd       = '0;
    bus_if.cmd_imm   = '0;
    exp_cnt          = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'(i);
    repeat (2) @(negedge clk);
    rf_rst = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    // Reset values.
    check("rst_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_rsp_ovf", 32'(bus_if.rsp_ovf), 32'd0);
    check("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("rst_addrs", {17'd0, rd_addr1, rd_addr2, wr_addr}, 32'd0);
    check("rst_op_shft", {23'd0, alu_op, alu_shft}, 32'd0);
    check("rst_imm", imm_data, 32'd0);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);

    // ADD r12 = r5 + r6.
    run_cmd(mk(0, 0, 12, 5, 6, 0), 32'h0, 0, 0, 0);
    check("add_r12", rf[12], 32'd11);

    // Overflowing ADD is suppressed and counted.
    run_cmd(mk(1, 0, 1, 0, 0, 0), 32'h7FFFFFFF, 0, 0, 0);
    run_cmd(mk(1, 0, 2, 0, 0, 0), 32'h1, 0, 0, 0);
    run_cmd(mk(0, 0, 3, 1, 2, 0), 32'h0, 0, 0, 0);
    check("ovf_r3", rf[3], 32'd3);
    check("ovf_cnt_1", 32'(ovf_cnt), 32'd1);

    // Illegal opcode, then SRA of a negative value.
    run_cmd(mk(0, 9, 7, 5, 6, 0), 32'h0, 0, 0, 0);
    check("illegal_r7", rf[7], 32'd7);
    run_cmd(mk(1, 0, 10, 0, 0, 0), 32'hFFFFFFEC, 0, 0, 0);
    run_cmd(mk(0, 6, 11, 10, 0, 2), 32'h0, 0, 0, 0);
    check("sra_r11", rf[11], 32'hFFFFFFFB);

    // Destination equal to both sources reads the pre-write value.
    run_cmd(mk(0, 0, 5, 5, 5, 0), 32'h0, 0, 0, 0);
    check("self_r5", rf[5], 32'd10);

    // Back-to-back commands with cmd_valid held high.
    c  = mk(0, 3, 13, 12, 7, 0);
    c2 = mk(1, 4, 14, 3, 9, 17);
    run_cmd(c, 32'h0, 1, c2, 32'hA5A5_0F0F);
    acc1 = last_acc;
    run_cmd(c2, 32'hA5A5_0F0F, 0, 0, 0);
    check("queued_gap", last_acc - acc1, 32'd3);

    // Random commands, including illegal opcodes and rd/rs aliasing.
    for (int k = 0; k < 80; k++) begin
      int unsigned op;
      op = ($urandom_range(0, 4) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      c  = mk($urandom_range(0, 3) == 0, op, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31));
      c[6:0] = 7'($urandom);
      run_cmd(c, $urandom, 0, 0, 0);
    end

    // Reset during EXEC drops the command.
    run_cmd(mk(1, 0, 4, 0, 0, 0), 32'hDEADBEEF, 0, 0, 0);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd       = mk(0, 0, 4, 5, 6, 0);
    bus_if.cmd_imm   = '0;
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("arst_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_hold_wr_en", 32'(wr_en), 32'd0);
      check("arst_hold_rsp", 32'(bus_if.rsp_valid), 32'd0);
    end
    rst     = 1'b0;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check("arst_after_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("arst_after_wr_en", 32'(wr_en), 32'd0);
    check("arst_after_rsp", 32'(bus_if.rsp_valid), 32'd0);
    @(negedge clk);
    check("arst_r4", rf[4], 32'hDEADBEEF);

    // Saturating overflow counter.
    run_cmd(mk(1, 0, 1, 0, 0, 0), 32'h80000000, 0, 0, 0);
    run_cmd(mk(1, 0, 2, 0, 0, 0), 32'h1, 0, 0, 0);
    for (int k = 0; k < 256; k++) run_cmd(mk(0, 1, 3, 1, 2, 0), 32'h0, 0, 0, 0);
    check("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);

    for (int i = 0; i < 32; i++) check("final_rf", rf[i], exp_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
